// File: rtl/piece_motion_ctrl.sv
// Falling-piece position controller: button edge detection, gravity, spawn/fall/lock FSM, top-out.
// Optional hard drop is enabled by defining HARD_DROP_EN.
module piece_motion_ctrl #(
  parameter int COLS      = 24,
  parameter int ROWS      = 24,
  parameter int CELL      = 20,
  parameter int TICK_DIV  = 3500000,
  parameter int SPAWN_COL = 14
) (
  input  logic       iVGA_CLK,
  input  logic       reset,
  input  logic       left_n,
  input  logic       right_n,
  input  logic       down_n,
  input  logic       rot_n,
  input  logic       hard_n,
  input  logic [2:0] piece_w,
  input  logic [2:0] piece_h,
  input  logic       blocked_l,
  input  logic       blocked_r,
  input  logic       blocked_d,
  input  logic       line_clear,
  output logic [4:0] col,
  output logic [4:0] row,
  output logic [9:0] ref_x,
  output logic [9:0] ref_y,
  output logic       tick,
  output logic       lock,
  output logic       rotate_req,
  output logic [3:0] level,
  output logic       top_out
);

  localparam int              DIV_W    = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [5:0]      COLS_W   = 6'(COLS);
  localparam logic [5:0]      ROWS_W   = 6'(ROWS);
  localparam logic [4:0]      SPAWN_C  = 5'(SPAWN_COL);
  localparam logic [9:0]      CELL_W   = 10'(CELL);

  localparam int B_LEFT  = 0;
  localparam int B_RIGHT = 1;
  localparam int B_DOWN  = 2;
  localparam int B_ROT   = 3;
  localparam int B_HARD  = 4;

  typedef enum logic [2:0] {
    ST_SPAWN = 3'd0,
    ST_FALL  = 3'd1,
    ST_LOCK  = 3'd2,
`ifdef HARD_DROP_EN
    ST_DROP  = 3'd4,
`endif
    ST_HALT  = 3'd3
  } state_t;

  state_t           state_r;
  logic [4:0]       col_r;
  logic [4:0]       row_r;
  logic [4:0]       grav_r;
  logic [3:0]       level_r;
  logic             lock_r;
  logic             rotate_req_r;
  logic             top_out_r;
  logic [DIV_W-1:0] div_r;

  logic [4:0] sync1_r;
  logic [4:0] sync2_r;
  logic [4:0] prev_r;
  logic [4:0] press_r;

  logic [4:0] btn_raw_s;
  logic [4:0] period_s;
  logic       grav_due_s;
  logic       fall_step_s;
  logic       left_ev_s;
  logic       right_ev_s;
  logic       bottom_s;
  logic       can_left_s;
  logic       can_right_s;

  assign btn_raw_s = {hard_n, rot_n, down_n, right_n, left_n};

  // Two-flop synchronizer, previous-value flop and registered 1->0 press events.
  always_ff @(posedge iVGA_CLK or posedge reset) begin
    if (reset) begin
      sync1_r <= 5'b11111;
      sync2_r <= 5'b11111;
      prev_r  <= 5'b11111;
      press_r <= 5'b00000;
    end else begin
      sync1_r <= btn_raw_s;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      press_r <= prev_r & ~sync2_r;
    end
  end

  // Free-running gravity tick divider.
  always_ff @(posedge iVGA_CLK or posedge reset) begin
    if (reset) begin
      div_r <= {DIV_W{1'b0}};
    end else if (div_r == DIV_LAST) begin
      div_r <= {DIV_W{1'b0}};
    end else begin
      div_r <= div_r + DIV_W'(1);
    end
  end

  assign tick = (div_r == DIV_LAST);

  // >= rather than == so a level change that shortens the period mid-count still fires.
  assign period_s    = 5'd16 - {1'b0, level_r};
  assign grav_due_s  = tick && ((grav_r + 5'd1) >= period_s);
  assign fall_step_s = grav_due_s || press_r[B_DOWN];
  assign left_ev_s   = press_r[B_LEFT] && !press_r[B_RIGHT];
  assign right_ev_s  = press_r[B_RIGHT] && !press_r[B_LEFT];
  assign bottom_s    = (({1'b0, row_r} + {3'b000, piece_h}) >= ROWS_W);
  assign can_left_s  = (col_r != 5'd0) && !blocked_l;
  assign can_right_s = (({1'b0, col_r} + {3'b000, piece_w}) < COLS_W) && !blocked_r;

  // Spawn/fall/lock state machine with position, gravity, level and status registers.
  always_ff @(posedge iVGA_CLK or posedge reset) begin
    if (reset) begin
      state_r      <= ST_SPAWN;
      col_r        <= SPAWN_C;
      row_r        <= 5'd0;
      grav_r       <= 5'd0;
      level_r      <= 4'd0;
      lock_r       <= 1'b0;
      rotate_req_r <= 1'b0;
      top_out_r    <= 1'b0;
    end else begin
      lock_r       <= 1'b0;
      rotate_req_r <= 1'b0;
      if (tick) begin
        grav_r <= grav_due_s ? 5'd0 : (grav_r + 5'd1);
      end else begin
        grav_r <= grav_r;
      end
      if (line_clear && (state_r != ST_HALT) && (level_r != 4'd15)) begin
        level_r <= level_r + 4'd1;
      end else begin
        level_r <= level_r;
      end
      case (state_r)
        ST_SPAWN: begin
          col_r   <= SPAWN_C;
          row_r   <= 5'd0;
          grav_r  <= 5'd0;
          state_r <= ST_FALL;
        end
        ST_FALL: begin
          rotate_req_r <= press_r[B_ROT];
          // A fall step wins over any horizontal press in the same cycle.
          if (fall_step_s) begin
            if (blocked_d || bottom_s) begin
              state_r <= ST_LOCK;
              lock_r  <= 1'b1;
            end else begin
              row_r <= row_r + 5'd1;
            end
          end
`ifdef HARD_DROP_EN
          else if (press_r[B_HARD]) begin
            state_r <= ST_DROP;
          end
`endif
          else if (left_ev_s) begin
            if (can_left_s) begin
              col_r <= col_r - 5'd1;
            end
          end else if (right_ev_s) begin
            if (can_right_s) begin
              col_r <= col_r + 5'd1;
            end
          end
        end
`ifdef HARD_DROP_EN
        ST_DROP: begin
          if (blocked_d || bottom_s) begin
            state_r <= ST_LOCK;
            lock_r  <= 1'b1;
          end else begin
            row_r <= row_r + 5'd1;
          end
        end
`endif
        ST_LOCK: begin
          if (row_r == 5'd0) begin
            top_out_r <= 1'b1;
            state_r   <= ST_HALT;
          end else begin
            state_r <= ST_SPAWN;
          end
        end
        ST_HALT: begin
          state_r <= ST_HALT;
        end
        default: begin
          state_r <= ST_SPAWN;
        end
      endcase
    end
  end

  assign col        = col_r;
  assign row        = row_r;
  assign ref_x      = {5'b00000, col_r} * CELL_W;
  assign ref_y      = {5'b00000, row_r} * CELL_W;
  assign lock       = lock_r;
  assign rotate_req = rotate_req_r;
  assign level      = level_r;
  assign top_out    = top_out_r;

endmodule

// File: tb/tb_piece_motion_ctrl.sv
// Directed self-checking bench for piece_motion_ctrl with TICK_DIV=4 (64 cycles per row at level 0).
module tb_piece_motion_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] btn;           // {hard, rot, down, right, left}, active low
  logic [2:0] piece_w;
  logic [2:0] piece_h;
  logic       blocked_l;
  logic       blocked_r;
  logic       blocked_d;
  logic       line_clear;
  logic [4:0] col;
  logic [4:0] row;
  logic [9:0] ref_x;
  logic [9:0] ref_y;
  logic       tick;
  logic       lock;
  logic       rotate_req;
  logic [3:0] level;
  logic       top_out;

  int checks_cnt = 0;
  int fail_cnt   = 0;
  int edge_cnt;

  localparam logic [4:0] M_LEFT  = 5'b00001;
  localparam logic [4:0] M_RIGHT = 5'b00010;
  localparam logic [4:0] M_DOWN  = 5'b00100;
  localparam logic [4:0] M_ROT   = 5'b01000;
  localparam logic [4:0] M_HARD  = 5'b10000;

  piece_motion_ctrl #(
    .COLS(24), .ROWS(24), .CELL(20), .TICK_DIV(4), .SPAWN_COL(14)
  ) dut (
    .iVGA_CLK(clk), .reset(reset),
    .left_n(btn[0]), .right_n(btn[1]), .down_n(btn[2]), .rot_n(btn[3]), .hard_n(btn[4]),
    .piece_w(piece_w), .piece_h(piece_h),
    .blocked_l(blocked_l), .blocked_r(blocked_r), .blocked_d(blocked_d),
    .line_clear(line_clear),
    .col(col), .row(row), .ref_x(ref_x), .ref_y(ref_y),
    .tick(tick), .lock(lock), .rotate_req(rotate_req), .level(level), .top_out(top_out)
  );

  always #5 clk = ~clk;

  // Edges since reset release, used to keep presses clear of gravity steps.
  always @(posedge clk or posedge reset) begin
    if (reset) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    btn   = 5'b11111;
    cyc(2);
    check("rst_col", col, 14);
    check("rst_row", row, 0);
    check("rst_ref_x", ref_x, 280);
    check("rst_ref_y", ref_y, 0);
    check("rst_level", level, 0);
    check("rst_lock", lock, 0);
    check("rst_top_out", top_out, 0);
    reset = 1'b0;
  endtask

  // Press a button so that no gravity step falls inside the following six edges.
  task automatic press(input logic [4:0] mask);
    for (int i = 0; i < 64 && (edge_cnt % 64) > 50; i++) cyc(1);
    btn = ~mask;
    cyc(2);
    btn = 5'b11111;
    cyc(4);
  endtask

  initial begin
    int r0;
    int pulses;
    reset = 1'b1; btn = 5'b11111; piece_w = 3'd3; piece_h = 3'd2;
    blocked_l = 1'b0; blocked_r = 1'b0; blocked_d = 1'b0; line_clear = 1'b0;

    // Gravity timing and horizontal moves
    do_reset();
    cyc(63);
    check("grav_before", row, 0);
    cyc(1);
    check("grav_step", row, 1);
    press(M_LEFT);
    check("left_move", col, 13);
    check("left_ref_x", ref_x, 260);
    blocked_l = 1'b1;
    press(M_LEFT);
    check("left_blocked", col, 13);
    blocked_l = 1'b0;
    press(M_LEFT | M_RIGHT);
    check("left_right_same", col, 13);

    for (int i = 0; i < 64 && (edge_cnt % 64) > 50; i++) cyc(1);
    btn = ~M_ROT;
    cyc(2);
    btn = 5'b11111;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      if (rotate_req) pulses++;
    end
    check("rotate_pulses", pulses, 1);
    check("rotate_col", col, 13);

    for (int i = 0; i < 13; i++) press(M_LEFT);
    check("left_to_wall", col, 0);
    press(M_LEFT);
    check("left_wall", col, 0);
    for (int i = 0; i < 20; i++) press(M_RIGHT);
    check("right_to_20", col, 20);
    check("right_ref_x", ref_x, 400);
    press(M_RIGHT);
    check("right_to_21", col, 21);
    press(M_RIGHT);
    check("right_wall", col, 21);
    press(M_LEFT);
    blocked_r = 1'b1;
    press(M_RIGHT);
    check("right_blocked", col, 20);
    blocked_r = 1'b0;

    r0 = int'(row);
    press(M_DOWN);
    check("down_step", row, r0 + 1);

    // Left press whose update edge coincides with a gravity step is dropped
    for (int i = 0; i < 64 && (edge_cnt % 64) != 60; i++) cyc(1);
    r0 = int'(row);
    btn = ~M_LEFT;
    cyc(2);
    btn = 5'b11111;
    cyc(4);
    check("collide_col", col, 20);
    check("collide_row", row, r0 + 1);

    // Landing at the bottom and respawn
    do_reset();
    cyc(1408);
    check("land_row22", row, 22);
    check("land_ref_y", ref_y, 440);
    cyc(63);
    check("land_pre_lock", lock, 0);
    cyc(1);
    check("land_lock", lock, 1);
    check("land_lock_row", row, 22);
    cyc(1);
    check("land_lock_end", lock, 0);
    cyc(1);
    check("respawn_row", row, 0);
    check("respawn_col", col, 14);
    check("respawn_top_out", top_out, 0);

    // Level speed-up and saturation
    do_reset();
    for (int i = 0; i < 5; i++) begin
      line_clear = 1'b1; cyc(1); line_clear = 1'b0; cyc(1);
    end
    check("level_5", level, 5);
    for (int i = 0; i < 15; i++) begin
      line_clear = 1'b1; cyc(1); line_clear = 1'b0; cyc(1);
    end
    check("level_sat", level, 15);
    r0 = int'(row);
    cyc(8);
    check("level15_fall", row, r0 + 2);

    // Top-out with the floor blocked from spawn
    blocked_d = 1'b1;
    do_reset();
    cyc(63);
    check("top_pre_lock", lock, 0);
    cyc(1);
    check("top_lock", lock, 1);
    check("top_lock_row", row, 0);
    cyc(1);
    check("top_out_set", top_out, 1);
    check("top_lock_end", lock, 0);
    press(M_LEFT);
    press(M_DOWN);
    press(M_RIGHT);
    line_clear = 1'b1; cyc(1); line_clear = 1'b0; cyc(1);
    check("halt_col", col, 14);
    check("halt_row", row, 0);
    check("halt_level", level, 0);
    check("halt_top_out", top_out, 1);
    blocked_d = 1'b0;

`ifdef HARD_DROP_EN
    // Hard drop from row 3 with a one-cell-high piece
    piece_h = 3'd1;
    do_reset();
    cyc(192);
    check("hd_row3", row, 3);
    btn = ~M_HARD;
    cyc(2);
    btn = 5'b11111;
    cyc(2);
    check("hd_enter", row, 3);
    cyc(1);
    check("hd_row4", row, 4);
    cyc(19);
    check("hd_row23", row, 23);
    check("hd_no_lock", lock, 0);
    cyc(1);
    check("hd_lock", lock, 1);
    check("hd_lock_row", row, 23);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/piece_motion_ctrl.md
# piece_motion_ctrl

Parametrised falling-piece position controller for the VGA Tetris datapath. It generalises the per-shape movement logic to a configurable cell grid and piece bounding box. It adds button edge detection, a spawn/fall/lock state machine, level-scaled gravity and top-out detection. It sits between the button inputs and the collision checker, and feeds `ref_x`/`ref_y` to the renderer.

## Interface
- `COLS`, 24: playfield width in cells; range 4–32.
- `ROWS`, 24: playfield height in cells; range 4–32.
- `CELL`, 20: cell size in pixels.
- `TICK_DIV`, 3500000: `iVGA_CLK` cycles per gravity tick; must be ≥2.
- `SPAWN_COL`, 14: spawn column; `SPAWN_COL+4` must be ≤`COLS`.
- `iVGA_CLK` in 1: the only clock.
- `reset` in 1: asynchronous, active-high.
- `left_n`, `right_n`, `down_n`, `rot_n`, `hard_n` in 1 each: active-low buttons, asynchronous to the clock.
- `piece_w`, `piece_h` in 3 each: bounding box of the current piece in cells, 1–4.
- `blocked_l`, `blocked_r`, `blocked_d` in 1 each: collision checker result for a one-cell move from the current `col`/`row`.
- `line_clear` in 1: one-cycle pulse for each cleared line.
- `col` out 5, `row` out 5: piece origin in cells (top-left corner).
- `ref_x` out 10, `ref_y` out 10: `col*CELL` and `row*CELL`, combinational from the registers.
- `tick` out 1: one-cycle pulse each `TICK_DIV` cycles.
- `lock` out 1: one-cycle pulse when the piece lands.
- `rotate_req` out 1: one-cycle pulse for each `rot_n` press.
- `level` out 4: speed level.
- `top_out` out 1: sticky game-over flag.

## Operation
- **Reset values:** state `SPAWN`, `col=SPAWN_COL`, `row=0`, `level=0`, divider 0, gravity count 0, all pulse outputs 0, `top_out=0`, all synchronizer flops 1.
- **Button path:** each button uses a 2-flop synchronizer plus a previous-value flop. A press is a synced 1→0 transition, giving exactly one event per press, with no auto-repeat.
- **Divider:** counts 0..`TICK_DIV`-1 and wraps. `tick` is high in the cycle the count equals `TICK_DIV`-1. The divider runs in every state.
- **Gravity:** the period is `16-level` ticks. The gravity counter increments on each `tick`. A fall step is due when the counter reaches the period, and the counter then returns to 0. The counter clears in `SPAWN`.
- **SPAWN** (1 cycle): loads `col=SPAWN_COL`, `row=0`, then goes to `FALL`.
- **FALL:**
  - *Fall step (gravity or `down_n` press):* if `blocked_d` is set or `row+piece_h==ROWS`, go to `LOCK`. Otherwise `row+1`.
  - *Left press:* `col-1` only if `col>0` and `!blocked_l`.
  - *Right press:* `col+1` only if `col+piece_w<COLS` and `!blocked_r`.
  - *Left and right in the same cycle:* both are ignored.
  - *Horizontal move in the same cycle as a fall step:* the fall step is applied and the horizontal press is dropped.
  - *`rot_n` press:* pulses `rotate_req`. It has no position effect; the shape logic re-evaluates the bounding box.
- **LOCK** (1 cycle):
  - `lock`=1.
  - If `row==0`, set `top_out`.
  - Go to `SPAWN`, unless `top_out` is now set, in which case go to `HALT`.
- **HALT:** holds all position registers and ignores all presses. It is left only by `reset`.
- **Presses outside their state:** in `SPAWN`, `LOCK` and `HALT`, presses are discarded, not queued.
- **Level:** each `line_clear` pulse adds 1, saturating at 15. This applies in every state except `HALT`.
- **Widths:** `row+piece_h` and `col+piece_w` are computed at 6 bits, so there is no wrap. `ref_x`/`ref_y` are truncated to 10 bits.
- **Reset mid-operation:** returns immediately to the reset values; any in-flight press is lost.

## Timing
- Button low first sampled at edge k → event at edge k+2 → `col`/`row` register updates at edge k+3.
- `ref_x`/`ref_y` follow `col`/`row` in the same cycle.
- A gravity step registers on the edge ending the `tick` cycle that completes the period. Level 0 gives 16 ticks per row; level 15 gives 1 tick per row.
- Landing to next spawn: `LOCK` for 1 cycle, `SPAWN` for 1 cycle, then `FALL`. `lock` is high for exactly 1 cycle.
- `blocked_*` inputs must be valid in the same cycle as the current `col`/`row`. They are used unregistered.

## Configuration
- **`HARD_DROP_EN` defined:**
  - A `hard_n` press in `FALL` enters `DROP`.
  - `DROP` performs `row+1` every clock until `blocked_d` or the bottom is reached, then goes to `LOCK`.
  - All other presses are ignored in `DROP`. `tick`/`level` continue.
- **`HARD_DROP_EN` undefined:** `hard_n` is ignored and the `DROP` state is not built.

## Test plan
- **Reset and spawn:** `reset` pulse → `col=14`, `row=0`, `ref_x=280`, `ref_y=0`, `level=0`, `lock=0`. After 2 cycles the block is in `FALL`.
- **Gravity and landing:** `TICK_DIV=4`, `piece_h=2`, no blocks → `row` increments every 64 cycles. When `row=22`, the next step gives one `lock` pulse, then `col=14`, `row=0`.
- **Left wall:** `col=0`, left press → `col` stays 0. Right press with `col=21`, `piece_w=3` → `col` stays 21. Right press with `col=20` → `col=21`.
- **Level speed-up:** 20 `line_clear` pulses → `level=15`. The next fall occurs every 4 cycles (1 tick at `TICK_DIV=4`).
- **Top-out:** `blocked_d=1` held from spawn → `lock` pulse at `row=0` at the first gravity step, then `top_out=1`. Subsequent presses leave `col`/`row` unchanged.
- **Hard drop** (`HARD_DROP_EN` defined): `hard_n` press at `row=3`, `piece_h=1`, `ROWS=24` → `row` steps one per clock to 23, followed by a `lock` pulse.
